// File: rtl/wb_slow_bridge.sv
// ----------------------------------------------------------------------------
// wb_slow_bridge
//
// Purpose:
//   Wishbone slave that sits between one chip-select lane of a Wishbone
//   multiplexer and one slow user macro. The macro side advances only on a
//   clock-enable (mac_ce_o) that is high one cycle in every DIV wb_clk_i
//   cycles. Each strobed request is latched, offered to the macro, and
//   completed with a single-cycle ack carrying the read data. wbs_dat_o is
//   zero whenever wbs_ack_o is low, so several lanes can be OR-merged.
//
// Optional feature:
//   WB_TIMEOUT_EN - when defined, a transfer left pending for TIMEOUT_CYCLES
//                   cycles after entering REQ is force-acked with
//                   32'hDEAD_BEEF and a one-cycle timeout_o pulse.
//
// Parameters:
//   DIV             slow-domain divide ratio (>= 2)
//   AW              macro word-address width, taken from wbs_adr_i[AW+1:2]
//   TIMEOUT_CYCLES  forced-ack delay in wb_clk_i cycles (WB_TIMEOUT_EN only)
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_stb_i/we_i/sel_i/adr_i/dat_i   Wishbone request (stb held until ack)
//   wbs_ack_o, wbs_dat_o      one-cycle ack, read data (0 when no ack)
//   mac_ce_o                  slow clock-enable
//   mac_req_o                 request to macro
//   mac_we_o/sel_o/adr_o/dat_o   latched request fields
//   mac_rdy_i, mac_dat_i      macro completion and read data (sampled on ce)
//   busy_o                    high in any state except IDLE
//   timeout_o                 one-cycle pulse on forced completion
// ----------------------------------------------------------------------------
module wb_slow_bridge #(
    parameter int DIV            = 8,
    parameter int AW             = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          mac_ce_o,
    output logic          mac_req_o,
    output logic          mac_we_o,
    output logic [3:0]    mac_sel_o,
    output logic [AW-1:0] mac_adr_o,
    output logic [31:0]   mac_dat_o,
    input  logic          mac_rdy_i,
    input  logic [31:0]   mac_dat_i,
    output logic          busy_o,
    output logic          timeout_o
);

    localparam int DW = $clog2(DIV);

    // Elaboration-time parameter sanity checks.
    if (DIV < 2) begin : g_bad_div
        $error("wb_slow_bridge: DIV must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_slow_bridge: TIMEOUT_CYCLES must fit the 16-bit counter");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    // Only the word-address slice reaches the macro.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

    // ------------------------------------------------------------------
    // Free-running divider; ce is a decode of the count register.
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DW'(DIV - 1)) div_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) div_q <= '0;
        else          div_q <= div_d;
    end

    assign mac_ce_o = (div_q == DW'(DIV - 1));

    // ------------------------------------------------------------------
    // Optional timeout counter
    // ------------------------------------------------------------------
    logic to_hit;
`ifdef WB_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    state_t      state_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            to_cnt_q <= '0;                    // cleared as REQ is entered
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    // Fires on the last cycle so the forced ack lands TIMEOUT_CYCLES after REQ entry.
    assign to_hit = (state_q == S_REQ || state_q == S_WAIT) &&
                    (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    state_t state_q;
    assign to_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    logic          ack_q, req_q, busy_q, timeout_q, we_q;
    logic [31:0]   rdat_q, wdat_q;
    logic [3:0]    sel_q;
    logic [AW-1:0] adr_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
        end else begin
            // Ack, data and timeout are single-cycle pulses by default.
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wbs_stb_i) begin
                        we_q    <= wbs_we_i;
                        sel_q   <= wbs_sel_i;
                        adr_q   <= wbs_adr_i[AW+1:2];
                        wdat_q  <= wbs_dat_i;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (state_q == S_WAIT && mac_ce_o && mac_rdy_i) begin
                        if (wbs_stb_i) begin
                            ack_q   <= 1'b1;
                            rdat_q  <= we_q ? 32'h0 : mac_dat_i;
                            state_q <= S_ACK;
                        end else begin
                            busy_q  <= 1'b0;  // master abandoned the transfer
                            state_q <= S_IDLE;
                        end
                    end else if (to_hit) begin
                        req_q <= 1'b0;
                        if (wbs_stb_i) begin
                            ack_q     <= 1'b1;
                            rdat_q    <= 32'hDEAD_BEEF;
                            timeout_q <= 1'b1;
                            state_q   <= S_ACK;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (state_q == S_REQ && mac_ce_o) begin
                        // The macro samples req on this enable.
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_ACK: begin
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // Wait for the strobe to drop so a held strobe is not re-served.
                    if (!wbs_stb_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign mac_req_o = req_q;
    assign mac_we_o  = we_q;
    assign mac_sel_o = sel_q;
    assign mac_adr_o = adr_q;
    assign mac_dat_o = wdat_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_slow_bridge.sv
// ----------------------------------------------------------------------------
// tb_wb_slow_bridge
//
// Self-checking bench for wb_slow_bridge. Expected responses are queued when a
// request is issued; a negedge monitor pops and compares them on every ack and
// checks that data/timeout stay 0 outside ack. Scenario tasks run in order.
// ----------------------------------------------------------------------------
module tb_wb_slow_bridge;

    localparam int DIV = 8;
    localparam int AW  = 8;
    localparam int TO  = 64;

    typedef struct packed {
        logic [31:0] dat;
        logic        to;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic          ack;
    logic [31:0]   rdat;
    logic          ce, req, mwe;
    logic [3:0]    msel;
    logic [AW-1:0] madr;
    logic [31:0]   mdat;
    logic          rdy;
    logic [31:0]   mac_rd;
    logic          busy, tmo;

    int checks = 0;
    int errors = 0;
    int req_windows = 0;
    int ack_count = 0;
    logic req_prev = 1'b0;
    resp_t exp_q[$];
    resp_t cur;

    always #5 clk = ~clk;

    wb_slow_bridge #(.DIV(DIV), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .mac_ce_o (ce),
        .mac_req_o(req),
        .mac_we_o (mwe),
        .mac_sel_o(msel),
        .mac_adr_o(madr),
        .mac_dat_o(mdat),
        .mac_rdy_i(rdy),
        .mac_dat_i(mac_rd),
        .busy_o   (busy),
        .timeout_o(tmo)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: ack with dat=%h, none expected", rdat);
            end else begin
                cur = exp_q.pop_front();
                if (rdat !== cur.dat || tmo !== cur.to) begin
                    errors++;
                    $display("FAIL ack_data: got dat=%h to=%b, want dat=%h to=%b",
                             rdat, tmo, cur.dat, cur.to);
                end
            end
        end else if (!rst) begin
            checks++;
            if (rdat !== 32'h0 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero: got dat=%h to=%b ack=%b, want 0/0", rdat, tmo, ack);
            end
        end
        if (req === 1'b1 && !req_prev) req_windows++;
        req_prev = (req === 1'b1);
    end

    task automatic start_txn(input logic w, input logic [3:0] s,
                             input logic [31:0] a, input logic [31:0] d);
        stb  = 1'b1;
        we   = w;
        sel  = s;
        adr  = a;
        wdat = d;
    endtask

    // Waits up to budget negedges for ack; n counts clock edges since the call.
    task automatic wait_ack(input int budget, output int n, output bit seen);
        n = 0;
        seen = 0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) seen = 1;
        end
    endtask

    // Full transfer: issue, expect one ack, check latched fields, hold stb for
    // `hold` extra cycles, then release and expect IDLE.
    task automatic do_txn(input string name, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_dat, input int hold);
        int  n, w0;
        bit  seen;
        resp_t r;
        w0 = req_windows;
        @(negedge clk);
        start_txn(w, s, a, d);
        r.dat = exp_dat;
        r.to  = 1'b0;
        exp_q.push_back(r);
        wait_ack(4 * DIV, n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_ack_seen: no ack within %0d cycles", name, 4 * DIV);
            exp_q.delete();
        end else if (n < DIV + 2 || n > 2 * DIV + 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d..%0d", name, n, DIV + 2, 2 * DIV + 2);
        end
        checks++;
        if (mwe !== w || msel !== s || madr !== a[AW+1:2] || mdat !== d) begin
            errors++;
            $display("FAIL %s_mac_fields: got we=%b sel=%b adr=%h dat=%h, want %b %b %h %h",
                     name, mwe, msel, madr, mdat, w, s, a[AW+1:2], d);
        end
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || req !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: got busy=%b req=%b, want 1/0", name, busy, req);
            end
        end
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_windows - w0 !== 1) begin
            errors++;
            $display("FAIL %s_done: got busy=%b req_windows=%0d, want 0/1", name, busy, req_windows - w0);
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        stb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start_txn(1'b1, 4'hF, 32'h3000_00FC, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ack, rdat, ce, req, mwe, msel, madr, mdat, busy, tmo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h ce=%b req=%b we=%b sel=%h adr=%h mdat=%h busy=%b to=%b, want all 0",
                     ack, rdat, ce, req, mwe, msel, madr, mdat, busy, tmo);
        end
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n = 1;
        while (ce !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== DIV) begin
            errors++;
            $display("FAIL reset_first_ce: got cycle %0d, want %0d", n, DIV);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ce !== 1'b1 && n < 4 * DIV);
        checks++;
        if (n !== DIV) begin
            errors++;
            $display("FAIL ce_period: got %0d, want %0d", n, DIV);
        end
    endtask

    task automatic test_read;
        rdy    = 1'b1;
        mac_rd = 32'h1234_5678;
        do_txn("read", 1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'h1234_5678, 0);
        checks++;
        if (madr !== 8'h04) begin
            errors++;
            $display("FAIL read_adr: got %h, want 04", madr);
        end
    endtask

    task automatic test_write;
        rdy    = 1'b1;
        mac_rd = 32'h7777_1111;
        do_txn("write", 1'b1, 4'b0011, 32'h3000_0208, 32'hA5A5_0F0F, 32'h0, 0);
    endtask

    task automatic test_held_strobe;
        rdy    = 1'b1;
        mac_rd = 32'h0BAD_F00D;
        do_txn("held", 1'b0, 4'h1, 32'h3000_0044, 32'h0, 32'h0BAD_F00D, 5);
        mac_rd = 32'h5555_AAAA;
        do_txn("reraise", 1'b0, 4'h2, 32'h3000_0048, 32'h0, 32'h5555_AAAA, 0);
    endtask

    task automatic test_abort;
        int n, a0;
        rdy = 1'b0;
        a0  = ack_count;
        @(negedge clk);
        start_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0);
        n = 0;
        while (req !== 1'b1 && n < 4 * DIV) begin @(negedge clk); n++; end
        while (req !== 1'b0 && n < 4 * DIV) begin @(negedge clk); n++; end
        checks++;
        if (req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach_wait: got req=%b busy=%b, want 0/1", req, busy);
        end
        stb = 1'b0;
        repeat (3) @(negedge clk);
        rdy    = 1'b1;
        mac_rd = 32'hFEED_0001;
        repeat (2 * DIV + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack_count !== a0) begin
            errors++;
            $display("FAIL abort_no_ack: got busy=%b acks=%0d, want 0/0", busy, ack_count - a0);
        end
        mac_rd = 32'hCAFE_0001;
        do_txn("after_abort", 1'b0, 4'hF, 32'h3000_0024, 32'h0, 32'hCAFE_0001, 0);
    endtask

    task automatic test_timeout;
        int n;
        bit seen;
        resp_t r;
        rdy = 1'b0;
        @(negedge clk);
        start_txn(1'b0, 4'hF, 32'h3000_0030, 32'h0);
`ifdef WB_TIMEOUT_EN
        r.dat = 32'hDEAD_BEEF;
        r.to  = 1'b1;
        exp_q.push_back(r);
        wait_ack(4 * TO, n, seen);
        checks++;
        // One edge to enter REQ plus TO cycles counted from REQ entry.
        if (!seen || n !== TO + 1) begin
            errors++;
            $display("FAIL timeout_ack: seen=%b at %0d, want ack at %0d", seen, n, TO + 1);
            exp_q.delete();
        end
        @(negedge clk);
        stb = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b, want 0", busy);
        end
`else
        r.dat = 32'h0;
        r.to  = 1'b0;
        wait_ack(2000, n, seen);
        checks++;
        if (seen || busy !== 1'b1 || r.to !== tmo) begin
            errors++;
            $display("FAIL no_timeout: got ack=%b busy=%b to=%b after %0d, want 0/1/0", seen, busy, tmo, n);
        end
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL recover_reset: got busy=%b, want 0", busy);
        end
`endif
    endtask

    initial begin
        rst    = 1'b1;
        stb    = 1'b0;
        we     = 1'b0;
        sel    = 4'h0;
        adr    = 32'h0;
        wdat   = 32'h0;
        rdy    = 1'b0;
        mac_rd = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_held_strobe();
        test_abort();
        test_timeout();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expect: got %0d unconsumed, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
